// File: rtl/processing_hw_div_udiv_25ns_13ns_12_seq_pkg.sv
// Shared widths, FSM states and constants for the restoring 25/13 -> 12 divider.
// PROCESSING_HW_DIV_ROUND_EN selects round-half-up quotients in the top module.
package processing_hw_div_pkg;
  localparam int DIVIDEND_W = 25;
  localparam int DIVISOR_W  = 13;
  localparam int QUOT_W     = 12;
  localparam int CNT_W      = 4;

  // One load value per quotient bit, plus a final cycle that registers the result.
  localparam logic [CNT_W-1:0]  CNT_LOAD = 4'd12;
  localparam logic [QUOT_W-1:0] QUOT_SAT = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic round_up(input logic [DIVISOR_W-1:0] rem,
                                    input logic [DIVISOR_W-1:0] dvs);
    return {rem, 1'b0} >= {1'b0, dvs};
  endfunction
endpackage

// File: rtl/processing_hw_div_udiv_25ns_13ns_12_seq_if.sv
// Operand/result handshake bundle between a producer/consumer and the divider.
interface processing_hw_div_udiv_25ns_13ns_12_seq_if;
  import processing_hw_div_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  ovf;
  logic                  dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dz
  );
endinterface

// File: rtl/processing_hw_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract when it fits.
module processing_hw_div_step
  import processing_hw_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] r_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] r_next_o,
  output logic                 q_bit_o
);
  logic [DIVISOR_W:0] t_s;

  assign t_s = {r_i, bit_i};

  // The difference is below the divisor, so the 13-bit modular subtract is exact.
  always_comb begin
    q_bit_o  = 1'b0;
    r_next_o = t_s[DIVISOR_W-1:0];
    if (t_s >= {1'b0, divisor_i}) begin
      q_bit_o  = 1'b1;
      r_next_o = t_s[DIVISOR_W-1:0] - divisor_i;
    end else begin
      q_bit_o  = 1'b0;
      r_next_o = t_s[DIVISOR_W-1:0];
    end
  end
endmodule

// File: rtl/processing_hw_div_udiv_25ns_13ns_12_seq.sv
// Iterative restoring unsigned divider, 25-bit dividend / 13-bit divisor, fixed 13-cycle latency.
// Define PROCESSING_HW_DIV_ROUND_EN for round-half-up quotients (remainder stays truncating).
module processing_hw_div_udiv_25ns_13ns_12_seq
  import processing_hw_div_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   ce,
  processing_hw_div_udiv_25ns_13ns_12_seq_if.slave bus
);
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [QUOT_W-1:0]     dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [QUOT_W-1:0]     quo_q, quo_d;
  logic                  dz_q, dz_d;
  logic                  ovf_q, ovf_d;
  logic [QUOT_W-1:0]     quot_out_q, quot_out_d;
  logic [DIVISOR_W-1:0]  rem_out_q, rem_out_d;
  logic                  ovf_out_q, ovf_out_d;
  logic                  dz_out_q, dz_out_d;

  logic [DIVISOR_W-1:0]  step_rem_s;
  logic                  step_q_bit_s;
  logic [QUOT_W-1:0]     quo_fin_s;

  processing_hw_div_step u_step (
    .r_i       (rem_q),
    .bit_i     (dvd_q[QUOT_W-1]),
    .divisor_i (dvs_q),
    .r_next_o  (step_rem_s),
    .q_bit_o   (step_q_bit_s)
  );

`ifdef PROCESSING_HW_DIV_ROUND_EN
  assign quo_fin_s = (round_up(rem_q, dvs_q) && (quo_q != QUOT_SAT)) ? quo_q + 12'd1 : quo_q;
`else
  assign quo_fin_s = quo_q;
`endif

  // Next-state and datapath: capture in IDLE, one bit per CALC cycle, result register on exit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    ovf_out_d  = ovf_out_q;
    dz_out_d   = dz_out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
          cnt_d   = CNT_LOAD;
          dvd_d   = bus.dividend[QUOT_W-1:0];
          dvs_d   = bus.divisor;
          rem_d   = bus.dividend[DIVIDEND_W-1:QUOT_W];
          quo_d   = {QUOT_W{1'b0}};
          dz_d    = (bus.divisor == 13'd0);
          ovf_d   = (bus.divisor != 13'd0) &&
                    (bus.dividend[DIVIDEND_W-1:QUOT_W] >= bus.divisor);
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          rem_d = step_rem_s;
          quo_d = {quo_q[QUOT_W-2:0], step_q_bit_s};
          dvd_d = {dvd_q[QUOT_W-2:0], 1'b0};
        end else begin
          state_d   = DONE;
          ovf_out_d = ovf_q;
          dz_out_d  = dz_q;
          if (dz_q || ovf_q) begin
            quot_out_d = QUOT_SAT;
            rem_out_d  = 13'd0;
          end else begin
            quot_out_d = quo_fin_s;
            rem_out_d  = rem_q;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; ce low freezes everything, including the handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      dvd_q      <= 12'd0;
      dvs_q      <= 13'd0;
      rem_q      <= 13'd0;
      quo_q      <= 12'd0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      quot_out_q <= 12'd0;
      rem_out_q  <= 13'd0;
      ovf_out_q  <= 1'b0;
      dz_out_q   <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      ovf_out_q  <= ovf_out_d;
      dz_out_q   <= dz_out_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quot_out_q;
  assign bus.remainder = rem_out_q;
  assign bus.ovf       = ovf_out_q;
  assign bus.dz        = dz_out_q;
endmodule
